ddr_port1_reader: RTL

- Read-side counterpart to the port-0 frame writer.
- Fetches rendered Mandelbrot pixel words from DDR2 MCB port 1 in fixed-length read bursts and streams them to the HDMI scanout path over a valid/ready interface.
- Walks the frame buffer linearly, wraps at frame end and marks the first word of every frame.

---
 rtl/ddr_port1_reader_if.sv | 28 ++
 rtl/ddr_port1_reader.sv | 123 ++++++++++++
 2 files changed

// File: rtl/ddr_port1_reader_if.sv
// ddr_port1_reader_if: MCB port-1 read command/data bus plus the pixel stream toward scanout.
// master = reader side, slave = MCB model / scanout sink.
interface ddr_port1_reader_if;
  logic        p1_cmd_en;
  logic [2:0]  p1_cmd_instr;
  logic [5:0]  p1_cmd_bl;
  logic [29:0] p1_cmd_byte_addr;
  logic        p1_cmd_full;
  logic        p1_rd_en;
  logic [31:0] p1_rd_data;
  logic        p1_rd_empty;
  logic [31:0] pix_data;
  logic        pix_valid;
  logic        pix_sof;
  logic        pix_ready;

  modport master (
    output p1_cmd_en, p1_cmd_instr, p1_cmd_bl, p1_cmd_byte_addr, p1_rd_en,
    output pix_data, pix_valid, pix_sof,
    input  p1_cmd_full, p1_rd_data, p1_rd_empty, pix_ready
  );

  modport slave (
    input  p1_cmd_en, p1_cmd_instr, p1_cmd_bl, p1_cmd_byte_addr, p1_rd_en,
    input  pix_data, pix_valid, pix_sof,
    output p1_cmd_full, p1_rd_data, p1_rd_empty, pix_ready
  );
endinterface

// File: rtl/ddr_port1_reader.sv
// ddr_port1_reader: walks the frame buffer in fixed read bursts on MCB port 1 and streams words out.
// Optional double buffering (swap on frame_ready at frame wrap) under `DDR_RD_DBLBUF_EN.
module ddr_port1_reader #(
  parameter logic [29:0] BASE_ADDR   = 30'h0000000,
  parameter logic [29:0] BASE_ADDR1  = 30'h0400000,
  parameter int unsigned BURST_LEN   = 32,
  parameter int unsigned FRAME_WORDS = 921600
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               mem_calib_done,
  input  logic               frame_ready,
  ddr_port1_reader_if.master bus
);
  localparam int unsigned BEAT_W = 6;
  localparam int unsigned OFF_W  = 20;
  localparam int unsigned ADDR_W = 30;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [OFF_W-1:0]  OFF_STEP  = OFF_W'(BURST_LEN);
  localparam logic [OFF_W-1:0]  OFF_LAST  = OFF_W'(FRAME_WORDS - BURST_LEN);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t            state_q, state_d;
  logic [OFF_W-1:0]  word_off_q, word_off_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              cmd_en_q, cmd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] base;
  logic              pix_valid_c, pix_sof_c, xfer_c, frame_wrap_c;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= IDLE;
      word_off_q <= '0;
      beat_cnt_q <= '0;
      cmd_en_q   <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      word_off_q <= word_off_d;
      beat_cnt_q <= beat_cnt_d;
      cmd_en_q   <= cmd_en_d;
      addr_q     <= addr_d;
    end
  end

  // One command in flight: issue in CMD, drain exactly one burst in DATA, then re-arm.
  always_comb begin
    state_d      = state_q;
    word_off_d   = word_off_q;
    beat_cnt_d   = beat_cnt_q;
    cmd_en_d     = 1'b0;
    addr_d       = addr_q;
    pix_valid_c  = 1'b0;
    pix_sof_c    = 1'b0;
    xfer_c       = 1'b0;
    frame_wrap_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_calib_done) state_d = CMD;
      end
      CMD: begin
        if (!mem_calib_done) begin
          state_d = IDLE;
        end else if (!bus.p1_cmd_full) begin
          cmd_en_d   = 1'b1;
          addr_d     = base + ADDR_W'({word_off_q, 2'b00});
          beat_cnt_d = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        pix_valid_c = !bus.p1_rd_empty;
        pix_sof_c   = pix_valid_c && (word_off_q == '0) && (beat_cnt_q == '0);
        xfer_c      = pix_valid_c && bus.pix_ready;
        if (xfer_c) begin
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          if (beat_cnt_q == LAST_BEAT) begin
            frame_wrap_c = (word_off_q == OFF_LAST);
            word_off_d   = frame_wrap_c ? '0 : word_off_q + OFF_STEP;
            state_d      = mem_calib_done ? CMD : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DDR_RD_DBLBUF_EN
  logic buf_sel_q, pending_q;

  // A frame_ready arriving in the wrap cycle itself is honoured at that wrap.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      buf_sel_q <= 1'b0;
      pending_q <= 1'b0;
    end else if (frame_wrap_c) begin
      if (pending_q || frame_ready) buf_sel_q <= ~buf_sel_q;
      pending_q <= 1'b0;
    end else if (frame_ready) begin
      pending_q <= 1'b1;
    end
  end

  assign base = buf_sel_q ? BASE_ADDR1 : BASE_ADDR;
`else
  logic unused_dblbuf;

  assign base          = BASE_ADDR;
  assign unused_dblbuf = ^{frame_ready, BASE_ADDR1, frame_wrap_c};
`endif

  assign bus.p1_cmd_en        = cmd_en_q;
  assign bus.p1_cmd_instr     = 3'b001;
  assign bus.p1_cmd_bl        = LAST_BEAT;
  assign bus.p1_cmd_byte_addr = addr_q;
  assign bus.p1_rd_en         = xfer_c;
  assign bus.pix_valid        = pix_valid_c;
  assign bus.pix_sof          = pix_sof_c;
  // Data is forced to zero when not valid so idle/reset outputs read as 0.
  assign bus.pix_data         = pix_valid_c ? bus.p1_rd_data : '0;
endmodule
